bmp_stream_reader: RTL

- Parses a 24-bit uncompressed BMP file arriving as a byte stream and emits RGB pixels in raster order with row/column coordinates.
- Strips the 54-byte header and validates it. Skips bytes up to the pixel-data offset and discards row padding.
- Converts BMP bottom-up row order into image row indices.
- Acts as the source side of the sobel pipeline, mirroring the BMP writer at the output end.

---
 rtl/bmp_stream_reader_if.sv | 40 ++++
 rtl/bmp_stream_reader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_stream_reader_if.sv
// ---------------------------------------------------------------------------
// bmp_stream_reader_if
//   Bundles the two streams around the BMP reader:
//     - file byte stream   : in_data / in_valid / in_ready
//     - pixel output stream: dataPixel_{r,g,b}, out_valid / out_ready,
//                            out_row, out_col, out_sof, out_eol, out_eof
//   Modports:
//     slave  - the reader itself (consumes bytes, produces pixels)
//     master - the environment (file source and pixel sink)
//   Parameter COORD_W must match the reader's COORD_W.
// ---------------------------------------------------------------------------
interface bmp_stream_reader_if #(
    parameter int COORD_W = 16
) ();
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         dataPixel_r;
    logic [7:0]         dataPixel_g;
    logic [7:0]         dataPixel_b;
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] out_row;
    logic [COORD_W-1:0] out_col;
    logic               out_sof;
    logic               out_eol;
    logic               out_eof;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, dataPixel_r, dataPixel_g, dataPixel_b, out_valid,
               out_row, out_col, out_sof, out_eol, out_eof
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, dataPixel_r, dataPixel_g, dataPixel_b, out_valid,
               out_row, out_col, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/bmp_stream_reader.sv
// ---------------------------------------------------------------------------
// bmp_stream_reader
//   Parses a 24-bit uncompressed BMP file delivered as a byte stream and
//   emits RGB pixels in raster order with image row/column coordinates.
//   The 54-byte header is checked, bytes up to the pixel-data offset are
//   skipped, row padding is dropped and the bottom-up file row order is
//   converted to image rows (row 0 = top).
//
//   Ports:
//     clk, rst       clock and synchronous active-high reset
//     bus (slave)    byte input stream + pixel output stream with
//                    coordinates and sof/eol/eof markers
//     img_width      parsed width  (updated at header byte 25)
//     img_height     parsed height (updated at header byte 25)
//     done           1-cycle pulse after the last pixel is accepted
//     err, err_code  sticky header error and its cause:
//                    1 magic, 2 bpp, 3 compression, 4 dimensions, 5 offset
//
//   Optional feature (macro BMP_TOPDOWN_EN):
//     when defined, a negative height is accepted as a top-down image;
//     img_height reports |height| and out_row follows file row order.
//     When undefined, a negative height is a dimension error (code 4).
// ---------------------------------------------------------------------------
module bmp_stream_reader #(
    parameter int MAX_WIDTH  = 160,
    parameter int MAX_HEIGHT = 120,
    parameter int COORD_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    bmp_stream_reader_if.slave bus,
    output logic [COORD_W-1:0] img_width,
    output logic [COORD_W-1:0] img_height,
    output logic               done,
    output logic               err,
    output logic [2:0]         err_code
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_SKIP = 3'd1,
        S_PIX  = 3'd2,
        S_PAD  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t state_reg, state_next;

    // header capture
    logic [5:0]         hdr_cnt_reg;
    logic [7:0]         magic0_reg;
    logic [31:0]        offset_reg;
    logic [31:0]        width_reg;
    logic [31:0]        height_reg;
    logic [15:0]        bpp_reg;
    logic [23:0]        comp_lo_reg;

    // stream position
    logic [31:0]        skip_rem_reg;
    logic [1:0]         pad_rem_reg;
    logic [1:0]         phase_reg;
    logic [COORD_W-1:0] col_reg;
    logic [COORD_W-1:0] frow_reg;
    logic [7:0]         b_hold_reg;
    logic [7:0]         g_hold_reg;

    // output pixel register
    logic [7:0]         r_reg, g_reg, b_reg;
    logic [COORD_W-1:0] row_out_reg, col_out_reg;
    logic               sof_reg, eol_reg, eof_reg;
    logic               out_valid_reg;

    logic [COORD_W-1:0] img_width_reg, img_height_reg;
    logic               done_reg, err_reg;
    logic [2:0]         err_code_reg;

`ifdef BMP_TOPDOWN_EN
    logic               topdown_reg;
    logic [31:0]        height_in_full;
    logic [31:0]        height_in_abs;
`endif

    // combinational helpers
    logic               in_ready_int;
    logic               accept;
    logic               magic_bad;
    logic [31:0]        comp_full;
    logic [31:0]        height_abs;
    logic [2:0]         chk_code;
    logic [1:0]         lane;
    logic               last_col;
    logic               last_row;
    logic               pix_r_acc;
    logic               row_end;
    logic [1:0]         pad_amt;
    logic               pad_end;
    logic [COORD_W-1:0] row_calc;

    assign accept    = bus.in_valid && in_ready_int;
    assign magic_bad = (magic0_reg != 8'd66) || (bus.in_data != 8'd77);
    // the top compression byte is still on the bus when the checks run
    assign comp_full = {bus.in_data, comp_lo_reg};
    // 4-byte fields all start at a byte index with [1:0] == 2
    assign lane      = hdr_cnt_reg[1:0] - 2'd2;

`ifdef BMP_TOPDOWN_EN
    assign height_abs     = height_reg[31] ? (~height_reg + 32'd1) : height_reg;
    assign height_in_full = {bus.in_data, height_reg[23:0]};
    assign height_in_abs  = height_in_full[31] ? (~height_in_full + 32'd1)
                                               : height_in_full;
`else
    assign height_abs = height_reg;
`endif

    // lowest code wins
    always_comb begin
        chk_code = 3'd0;
        if (bpp_reg != 16'd24)
            chk_code = 3'd2;
        else if (comp_full != 32'd0)
            chk_code = 3'd3;
        else if ((width_reg == 32'd0) || (width_reg > 32'(MAX_WIDTH)) ||
                 (height_abs == 32'd0) || (height_abs > 32'(MAX_HEIGHT)))
            chk_code = 3'd4;
        else if (offset_reg < 32'd54)
            chk_code = 3'd5;
    end

    assign last_col  = (col_reg == img_width_reg - COORD_W'(1));
    assign last_row  = (frow_reg == img_height_reg - COORD_W'(1));
    assign pix_r_acc = (state_reg == S_PIX) && accept && (phase_reg == 2'd2);
    assign row_end   = pix_r_acc && last_col;
    // padding of 3*width up to a multiple of 4 equals width mod 4
    assign pad_amt   = img_width_reg[1:0];
    assign pad_end   = (state_reg == S_PAD) && accept && (pad_rem_reg == 2'd1);

`ifdef BMP_TOPDOWN_EN
    assign row_calc = topdown_reg ? frow_reg
                                  : (img_height_reg - COORD_W'(1) - frow_reg);
`else
    assign row_calc = img_height_reg - COORD_W'(1) - frow_reg;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_HDR;
        else
            state_reg <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_HDR: begin
                if (accept) begin
                    if ((hdr_cnt_reg == 6'd1) && magic_bad)
                        state_next = S_ERR;
                    else if ((hdr_cnt_reg == 6'd33) && (chk_code != 3'd0))
                        state_next = S_ERR;
                    else if (hdr_cnt_reg == 6'd53)
                        state_next = (offset_reg > 32'd54) ? S_SKIP : S_PIX;
                end
            end
            S_SKIP: begin
                if (accept && (skip_rem_reg == 32'd1))
                    state_next = S_PIX;
            end
            S_PIX: begin
                if (row_end) begin
                    if (pad_amt != 2'd0)
                        state_next = S_PAD;
                    else if (last_row)
                        state_next = S_DONE;
                end
            end
            S_PAD: begin
                if (pad_end)
                    state_next = last_row ? S_DONE : S_PIX;
            end
            S_DONE: begin
                // the eof pixel may already have left while padding drained
                if (!out_valid_reg || bus.out_ready)
                    state_next = S_HDR;
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_HDR;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready_int = 1'b1;
        case (state_reg)
            S_PIX:   in_ready_int = !out_valid_reg || bus.out_ready;
            S_DONE:  in_ready_int = 1'b0;
            default: in_ready_int = 1'b1;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt_reg    <= '0;
            magic0_reg     <= '0;
            offset_reg     <= '0;
            width_reg      <= '0;
            height_reg     <= '0;
            bpp_reg        <= '0;
            comp_lo_reg    <= '0;
            skip_rem_reg   <= '0;
            pad_rem_reg    <= '0;
            phase_reg      <= '0;
            col_reg        <= '0;
            frow_reg       <= '0;
            b_hold_reg     <= '0;
            g_hold_reg     <= '0;
            r_reg          <= '0;
            g_reg          <= '0;
            b_reg          <= '0;
            row_out_reg    <= '0;
            col_out_reg    <= '0;
            sof_reg        <= 1'b0;
            eol_reg        <= 1'b0;
            eof_reg        <= 1'b0;
            out_valid_reg  <= 1'b0;
            img_width_reg  <= '0;
            img_height_reg <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            err_code_reg   <= '0;
`ifdef BMP_TOPDOWN_EN
            topdown_reg    <= 1'b0;
`endif
        end else begin
            done_reg <= (state_reg == S_DONE) && (state_next == S_HDR);

            // pixel handshake; a simultaneous reload keeps out_valid high
            if (out_valid_reg && bus.out_ready)
                out_valid_reg <= 1'b0;
            if (pix_r_acc)
                out_valid_reg <= 1'b1;

            if ((state_reg != S_ERR) && (state_next == S_ERR)) begin
                err_reg      <= 1'b1;
                err_code_reg <= (hdr_cnt_reg == 6'd1) ? 3'd1 : chk_code;
            end
            if (state_reg == S_ERR)
                out_valid_reg <= 1'b0;

            if ((state_reg == S_HDR) && accept) begin
                hdr_cnt_reg <= (hdr_cnt_reg == 6'd53) ? 6'd0 : hdr_cnt_reg + 6'd1;

                if (hdr_cnt_reg == 6'd0)
                    magic0_reg <= bus.in_data;
                if ((hdr_cnt_reg >= 6'd10) && (hdr_cnt_reg <= 6'd13))
                    offset_reg[{lane, 3'b000} +: 8] <= bus.in_data;
                if ((hdr_cnt_reg >= 6'd18) && (hdr_cnt_reg <= 6'd21))
                    width_reg[{lane, 3'b000} +: 8] <= bus.in_data;
                if ((hdr_cnt_reg >= 6'd22) && (hdr_cnt_reg <= 6'd25))
                    height_reg[{lane, 3'b000} +: 8] <= bus.in_data;
                case (hdr_cnt_reg)
                    6'd28:   bpp_reg[7:0]       <= bus.in_data;
                    6'd29:   bpp_reg[15:8]      <= bus.in_data;
                    6'd30:   comp_lo_reg[7:0]   <= bus.in_data;
                    6'd31:   comp_lo_reg[15:8]  <= bus.in_data;
                    6'd32:   comp_lo_reg[23:16] <= bus.in_data;
                    default: ;
                endcase

                // width is complete here; height's top byte is on the bus
                if (hdr_cnt_reg == 6'd25) begin
                    img_width_reg  <= width_reg[COORD_W-1:0];
`ifdef BMP_TOPDOWN_EN
                    img_height_reg <= height_in_abs[COORD_W-1:0];
                    topdown_reg    <= bus.in_data[7];
`else
                    img_height_reg <= height_reg[COORD_W-1:0];
`endif
                end

                if (hdr_cnt_reg == 6'd53) begin
                    skip_rem_reg <= offset_reg - 32'd54;
                    phase_reg    <= 2'd0;
                    col_reg      <= '0;
                    frow_reg     <= '0;
                end
            end

            if ((state_reg == S_SKIP) && accept)
                skip_rem_reg <= skip_rem_reg - 32'd1;

            if ((state_reg == S_PIX) && accept) begin
                case (phase_reg)
                    2'd0: begin
                        b_hold_reg <= bus.in_data;
                        phase_reg  <= 2'd1;
                    end
                    2'd1: begin
                        g_hold_reg <= bus.in_data;
                        phase_reg  <= 2'd2;
                    end
                    default: begin
                        phase_reg   <= 2'd0;
                        r_reg       <= bus.in_data;
                        g_reg       <= g_hold_reg;
                        b_reg       <= b_hold_reg;
                        row_out_reg <= row_calc;
                        col_out_reg <= col_reg;
                        sof_reg     <= (frow_reg == '0) && (col_reg == '0);
                        eol_reg     <= last_col;
                        eof_reg     <= last_col && last_row;
                        if (last_col) begin
                            col_reg     <= '0;
                            pad_rem_reg <= pad_amt;
                            // with padding, the row advances once it drains
                            if (pad_amt == 2'd0)
                                frow_reg <= frow_reg + COORD_W'(1);
                        end else begin
                            col_reg <= col_reg + COORD_W'(1);
                        end
                    end
                endcase
            end

            if ((state_reg == S_PAD) && accept) begin
                pad_rem_reg <= pad_rem_reg - 2'd1;
                if (pad_rem_reg == 2'd1)
                    frow_reg <= frow_reg + COORD_W'(1);
            end
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.dataPixel_r = r_reg;
    assign bus.dataPixel_g = g_reg;
    assign bus.dataPixel_b = b_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_row     = row_out_reg;
    assign bus.out_col     = col_out_reg;
    assign bus.out_sof     = sof_reg;
    assign bus.out_eol     = eol_reg;
    assign bus.out_eof     = eof_reg;

    assign img_width  = img_width_reg;
    assign img_height = img_height_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign err_code   = err_code_reg;

endmodule
